rtmc_spi_bridge: RTL and testbench

//  SPI slave (mode 0) to register-bus master. Sits upstream of the motor controller register bus.

---
 rtl/rtmc_spi_bridge.sv | 203 ++++++++++++++++++++
 tb/tb_rtmc_spi_bridge.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtmc_spi_bridge.sv
// SPI mode-0 slave that turns each 32-bit frame into one register-bus read or write.
// SPI pins are asynchronous to clk and are synchronized here; read data returns on MISO in the same frame.
module rtmc_spi_bridge #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdat,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdat,
  input  logic              reg_ack,
  output logic              busy,
  output logic              bus_err
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT_ACK
  } state_e;

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic [2:0]  sck_sync_q;
  logic [2:0]  cs_sync_q;
  logic [1:0]  mosi_sync_q;
  logic [1:0]  warm_q;
  logic        armed_q;

  logic        active_q;
  logic        done_q;
  logic [4:0]  bit_cnt_q;
  logic [30:0] rx_q;
  logic [15:0] tx_q;
  logic        miso_q;
  logic        rd_live_q;
  logic        is_rd_q;
  logic        bus_err_q;
  logic [ADDR_W-1:0] reg_addr_q;
  logic [DATA_W-1:0] reg_wdat_q;

  logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_bit;
  logic bit_ok, rd_req, wr_req;
  logic launch, ack_done, tmo_hit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      warm_q      <= '0;
      armed_q     <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[1:0], spi_sck};
      cs_sync_q   <= {cs_sync_q[1:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      // A CS held low through reset must not look like a frame start: wait to see CS high first.
      if (warm_q != 2'd2) warm_q <= warm_q + 2'd1;
      else if (cs_sync_q[1]) armed_q <= 1'b1;
    end
  end

  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
  assign cs_fall  = armed_q & cs_sync_q[2] & ~cs_sync_q[1];
  assign cs_rise  = ~cs_sync_q[2] & cs_sync_q[1];
  assign mosi_bit = mosi_sync_q[1];

  // bit_cnt_q counts rises already taken; the new bit is the (bit_cnt_q+1)-th.
  assign bit_ok = sck_rise & active_q & ~done_q;
  assign rd_req = bit_ok && (bit_cnt_q == 5'd15) && !rx_q[14];
  assign wr_req = bit_ok && (bit_cnt_q == 5'd31) && rx_q[30];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    launch   = 1'b0;
    ack_done = 1'b0;
    tmo_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req || wr_req) begin
          launch  = 1'b1;
          state_d = STROBE;
        end
      end
      STROBE: begin
        tmo_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (reg_ack) begin
          ack_done = 1'b1;
          state_d  = IDLE;
        end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
          tmo_hit = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      miso_q     <= 1'b0;
      rd_live_q  <= 1'b0;
      is_rd_q    <= 1'b0;
      bus_err_q  <= 1'b0;
      reg_addr_q <= '0;
      reg_wdat_q <= '0;
    end else begin
      if (cs_fall) begin
        active_q  <= 1'b1;
        done_q    <= 1'b0;
        bit_cnt_q <= '0;
        rx_q      <= '0;
        tx_q      <= '0;
        miso_q    <= 1'b0;
        bus_err_q <= 1'b0;
        rd_live_q <= 1'b0;
      end else if (cs_rise) begin
        active_q  <= 1'b0;
        done_q    <= 1'b0;
        bit_cnt_q <= '0;
        miso_q    <= 1'b0;
        rd_live_q <= 1'b0;
      end else begin
        if (bit_ok) begin
          rx_q      <= {rx_q[29:0], mosi_bit};
          bit_cnt_q <= bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd31) done_q <= 1'b1;
        end
        // Read data goes out from the 16th fall onward; everything else on MISO is 0.
        if (sck_fall && active_q) begin
          if (!done_q && bit_cnt_q[4]) begin
            miso_q <= tx_q[15];
            tx_q   <= {tx_q[14:0], 1'b0};
          end else begin
            miso_q <= 1'b0;
          end
        end
        // A read left over from an earlier CS window completes on the bus but its data is dropped.
        if ((ack_done || tmo_hit) && is_rd_q && rd_live_q)
          tx_q <= ack_done ? 16'(reg_rdat) : 16'hDEAD;
        if (ack_done || tmo_hit) rd_live_q <= 1'b0;
      end

      if (launch) begin
        is_rd_q   <= rd_req;
        rd_live_q <= rd_req;
        if (rd_req) begin
          reg_addr_q <= ADDR_W'({rx_q[6:0], mosi_bit});
        end else begin
          reg_addr_q <= ADDR_W'(rx_q[22:15]);
          reg_wdat_q <= DATA_W'({rx_q[14:0], mosi_bit});
        end
      end
      if (tmo_hit) bus_err_q <= 1'b1;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = ~cs_sync_q[1];
  assign reg_addr    = reg_addr_q;
  assign reg_wdat    = reg_wdat_q;
  assign reg_wr      = (state_q == STROBE) & ~is_rd_q;
  assign reg_rd      = (state_q == STROBE) & is_rd_q;
  assign busy        = (state_q != IDLE);
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_rtmc_spi_bridge.sv
// Bench for rtmc_spi_bridge: an SPI master and a register-bus target drive the bridge while
// a frame-level model predicts strobes, MISO words and bus_err for every frame.
`timescale 1ns/1ps
module tb_rtmc_spi_bridge;

  logic        clk;
  logic        rst;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdat;
  logic        reg_wr;
  logic        reg_rd;
  logic [15:0] reg_rdat;
  logic        reg_ack;
  logic        busy;
  logic        bus_err;

  rtmc_spi_bridge dut (
    .clk         (clk),
    .rst         (rst),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .reg_addr    (reg_addr),
    .reg_wdat    (reg_wdat),
    .reg_wr      (reg_wr),
    .reg_rd      (reg_rd),
    .reg_rdat    (reg_rdat),
    .reg_ack     (reg_ack),
    .busy        (busy),
    .bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit        is_rd;
    bit [7:0]  addr;
    bit [15:0] data;
  } txn_t;

  int   total = 0;
  int   bad   = 0;
  txn_t exp_q[$];

  bit        ack_en = 1'b1;
  bit [15:0] rd_val = 16'h0000;

  int        cyc = 0;
  int        strobe_cyc = 0, idle_cyc = 0, err_cyc = 0;
  int        rd_cnt = 0, wr_cnt = 0;
  bit [7:0]  last_addr;
  bit [15:0] last_wdat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Register-bus target: ack exactly one cycle after the strobe cycle.
  initial begin
    reg_ack  = 1'b0;
    reg_rdat = 16'h5A5A;
    forever begin
      @(negedge clk);
      if (!rst && (reg_wr || reg_rd) && ack_en) begin
        @(negedge clk);
        reg_ack  = 1'b1;
        reg_rdat = rd_val;
        @(negedge clk);
        reg_ack  = 1'b0;
        reg_rdat = 16'h5A5A;
      end
    end
  end

  // Compare process: every strobe must match the head of the expected queue, and the request
  // must stay on the bus for the whole outstanding transaction.
  initial begin
    bit   prev_strobe, prev_err, in_txn, strobe;
    txn_t cur;
    prev_strobe = 1'b0;
    prev_err    = 1'b0;
    in_txn      = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_strobe = 1'b0;
        prev_err    = 1'b0;
        in_txn      = 1'b0;
        continue;
      end
      strobe = reg_wr | reg_rd;
      if (strobe) begin
        check("strobe_single_cycle", prev_strobe, 0);
        check("strobe_one_kind", reg_wr & reg_rd, 0);
        check("strobe_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          check("strobe_kind_rd", reg_rd, cur.is_rd);
          check("strobe_addr", reg_addr, cur.addr);
          if (!cur.is_rd) check("strobe_wdat", reg_wdat, cur.data);
          in_txn = 1'b1;
        end
        strobe_cyc = cyc;
        last_addr  = reg_addr;
        last_wdat  = reg_wdat;
        if (reg_rd) rd_cnt++;
        if (reg_wr) wr_cnt++;
      end else if (in_txn && busy) begin
        check("hold_addr", reg_addr, cur.addr);
        if (!cur.is_rd) check("hold_wdat", reg_wdat, cur.data);
      end
      if (in_txn && !busy) begin
        in_txn   = 1'b0;
        idle_cyc = cyc;
      end
      if (bus_err && !prev_err) err_cyc = cyc;
      prev_strobe = strobe;
      prev_err    = bus_err;
    end
  end

  // SPI mode-0 master: MOSI changes on falls, MISO is sampled just before each rise.
  task automatic spi_frame(input bit [31:0] f, input int nbits, input int h,
                           output bit [31:0] word, output bit err_start);
    int k;
    word      = '0;
    spi_mosi  = f[31];
    spi_cs_n  = 1'b0;
    #(h * 10);
    err_start = bus_err;
    for (int i = 0; i < nbits; i++) begin
      word    = {word[30:0], spi_miso};
      spi_sck = 1'b1;
      #(h * 10);
      spi_sck = 1'b0;
      k = 30 - i;
      spi_mosi = (k >= 0) ? f[k] : 1'b1;
      #(h * 10);
    end
    spi_cs_n = 1'b1;
    #(h * 30);
  endtask

  // Frame-level model: a read needs 16 bits with cmd bit 0, a write all 32 bits with cmd bit 1.
  task automatic run_frame(input string tag, input bit [31:0] f, input int n, input int h,
                           output bit [31:0] word);
    txn_t t;
    bit   has, err_start;
    has = 1'b0;
    t   = '0;
    if (!f[31] && n >= 16) begin
      has = 1'b1; t.is_rd = 1'b1; t.addr = f[23:16];
    end else if (f[31] && n >= 32) begin
      has = 1'b1; t.is_rd = 1'b0; t.addr = f[23:16]; t.data = f[15:0];
    end
    if (has) exp_q.push_back(t);
    spi_frame(f, n, h, word, err_start);
    check({tag, "/err_clear_at_start"}, err_start, 0);
    check({tag, "/strobes_done"}, exp_q.size(), 0);
    check({tag, "/bus_err"}, bus_err, has && !ack_en);
    if (f[31])
      check({tag, "/miso_word"}, word, 32'h0);
    else if (n == 32)
      check({tag, "/miso_word"}, word, {16'h0, ack_en ? rd_val : 16'hDEAD});
  endtask

  initial begin
    bit [31:0] w;
    int        r0, w0;
    rst      = 1'b1;
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    #3;
    repeat (3) @(negedge clk);
    check("rst/strobes", {reg_wr, reg_rd, busy, bus_err}, 4'h0);
    check("rst/miso", {spi_miso, spi_miso_oe}, 2'b00);
    check("rst/addr", reg_addr, 8'h00);
    check("rst/wdat", reg_wdat, 16'h0000);
    rst = 1'b0;
    #200;

    // Plain write.
    w0 = wr_cnt;
    run_frame("write", 32'h8002_C105, 32, 10, w);
    check("write/count", wr_cnt - w0, 1);
    check("write/addr_lit", last_addr, 8'h02);
    check("write/wdat_lit", last_wdat, 16'hC105);
    check("write/busy_fall_latency", idle_cyc - strobe_cyc, 2);

    // Reset in the middle of a frame; the rest of that CS window must be ignored.
    spi_mosi = 1'b1;
    spi_cs_n = 1'b0;
    #100;
    repeat (10) begin
      spi_sck = 1'b1; #100; spi_sck = 1'b0; #100;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst/strobes", {reg_wr, reg_rd, busy, bus_err}, 4'h0);
    check("midrst/miso", {spi_miso, spi_miso_oe}, 2'b00);
    check("midrst/addr", reg_addr, 8'h00);
    check("midrst/wdat", reg_wdat, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (22) begin
      spi_sck = 1'b1; #100; spi_sck = 1'b0; #100;
    end
    spi_cs_n = 1'b1;
    #400;
    check("midrst/no_strobe", rd_cnt + wr_cnt - w0, 1);
    run_frame("after_rst", 32'h8055_1234, 32, 10, w);

    // Reads with the bus answering.
    r0 = rd_cnt;
    rd_val = 16'h0142;
    run_frame("read0", 32'h0000_1357, 32, 10, w);
    check("read0/word_lit", w, 32'h0000_0142);
    check("read0/count", rd_cnt - r0, 1);
    rd_val = 16'hA5C3;
    run_frame("read7f", 32'h007F_FFFF, 32, 10, w);

    // Read with no ack at all: bus error and DEAD on MISO.
    ack_en = 1'b0;
    run_frame("timeout", 32'h0010_0000, 32, 24, w);
    check("timeout/word_lit", w, 32'h0000_DEAD);
    check("timeout/err_latency", err_cyc - strobe_cyc, 16);
    check("timeout/busy_latency", idle_cyc - strobe_cyc, 16);
    ack_en = 1'b1;
    run_frame("after_timeout", 32'h8010_BEEF, 32, 10, w);

    // CS rises after 20 bits of a write: no write.
    w0 = wr_cnt;
    run_frame("abort_wr", 32'h8099_AAAA, 20, 10, w);
    check("abort_wr/no_write", wr_cnt - w0, 0);
    run_frame("after_abort", 32'h8033_0F0F, 32, 10, w);

    // Aborted read still hits the bus, but the next frame returns its own data.
    rd_val = 16'h1111;
    run_frame("abort_rd", 32'h0044_0000, 20, 10, w);
    rd_val = 16'h2222;
    run_frame("after_abort_rd", 32'h0045_0000, 32, 10, w);
    check("after_abort_rd/word_lit", w, 32'h0000_2222);

    // 40 edges at the minimum clock ratio: one write, extra bits ignored.
    w0 = wr_cnt;
    run_frame("overrun", 32'h80A5_3C3C, 40, 8, w);
    check("overrun/count", wr_cnt - w0, 1);
    check("overrun/wdat_lit", last_wdat, 16'h3C3C);

    #200;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
